// File: rtl/gpio_cmd_ctrl_v4_if.sv
// Host/FIFO bus bundle for gpio_cmd_ctrl_v4.
// Command handshake: SELECT_in acts as a level-encoded request. A command is
// taken once, on the first cycle SELECT_in[15:0] goes nonzero after having
// been zero. The host must return SELECT_in to zero before the next command.
// Every effect of a command appears exactly one clock later.
interface gpio_cmd_ctrl_v4_if #(
  parameter int CH_NUM  = 2,
  parameter int CNT_W   = 16,
  parameter int LVL_W   = 14,
  parameter int TRG_NUM = 2
) ();
  logic [31:0]                SELECT_in;
  logic [CH_NUM*32-1:0]       DATA_in;
  logic [CH_NUM*CNT_W-1:0]    DATAcnt_in;
  logic [CH_NUM-1:0]          full_in;
  logic [CH_NUM-1:0]          empty_in;
  logic [31:0]                GPIO_out;
  logic                       _RESET_out;
  logic [CH_NUM-1:0]          DATAread_out;
  logic                       SLEAP_out;
  logic [TRG_NUM*2*LVL_W-1:0] TRGLEVEL_out;
  logic [1:0]                 STATE_out;

  // Controller side
  modport slave (
    input  SELECT_in, DATA_in, DATAcnt_in, full_in, empty_in,
    output GPIO_out, _RESET_out, DATAread_out, SLEAP_out, TRGLEVEL_out, STATE_out
  );

  // Host / FIFO side
  modport master (
    output SELECT_in, DATA_in, DATAcnt_in, full_in, empty_in,
    input  GPIO_out, _RESET_out, DATAread_out, SLEAP_out, TRGLEVEL_out, STATE_out
  );
endinterface

// File: rtl/gpio_cmd_ctrl_v4.sv
// GPIO command controller: decodes host command words, runs a SLEEP/RUN FSM,
// issues acquisition-reset and FIFO read pulses, holds trigger levels and
// drives a registered readback word (inquiry status or FIFO data).
// Optional feature macro: GPIOCTRL_ERRFLAG_EN adds sticky underflow/illegal
// flags reported in inquiry bits [29:28]; without it those bits read 0.
module gpio_cmd_ctrl_v4 #(
  parameter int CH_NUM  = 2,
  parameter int CNT_W   = 16,
  parameter int LVL_W   = 14,
  parameter int TRG_NUM = 2
) (
  input logic sys_clk,
  input logic _RESET_in,
  gpio_cmd_ctrl_v4_if.slave bus
);

  typedef enum logic [1:0] {
    SLEEP = 2'b00,
    RUN   = 2'b01
  } state_t;

  state_t state_q, state_d;

  // Command detection
  logic [15:0] sel_prev_q;
  logic        arm_q;
  logic        cmd_nz, cmd_acc;
  logic [7:0]  cmd_fn;
  logic [3:0]  cmd_idx;
  logic [15:0] cmd_pay;
  logic        ch_idx_ok, trg_idx_ok, legal;
  logic        do_start, do_inq, do_read, do_stop;

  // Channel views padded to 16 entries so a 4-bit index is always in range
  logic [31:0] data_arr [16];
  logic [15:0] cnt_arr  [16];
  logic [15:0] full_arr, empty_arr;

  // Readback and pulse state
  logic              mode_q, mode_d;   // 0 = inquiry word, 1 = FIFO data
  logic [3:0]        idx_q, idx_d;
  logic [31:0]       gpio_q, gpio_d;
  logic              rst_out_q, rst_out_d;
  logic [CH_NUM-1:0] rd_q, rd_d;

  // Trigger levels
  logic [LVL_W-1:0]   h_q [TRG_NUM];
  logic [LVL_W-1:0]   l_q [TRG_NUM];
  logic [TRG_NUM-1:0] wr_h, wr_l;

  logic uflow_w, illegal_w;

  assign cmd_fn  = bus.SELECT_in[7:0];
  assign cmd_idx = bus.SELECT_in[11:8];
  assign cmd_pay = bus.SELECT_in[31:16];
  assign cmd_nz  = |bus.SELECT_in[15:0];
  // arm_q blocks a word that was already nonzero when reset released
  assign cmd_acc = cmd_nz && (sel_prev_q == 16'd0) && arm_q;

  assign ch_idx_ok  = ({1'b0, cmd_idx} < 5'(CH_NUM));
  assign trg_idx_ok = ({1'b0, cmd_idx} < 5'(TRG_NUM));
  assign legal      = $onehot(cmd_fn) && ((|cmd_fn[3:0]) ? ch_idx_ok : trg_idx_ok);

  assign do_start = cmd_acc && legal && cmd_fn[0];
  assign do_inq   = cmd_acc && legal && cmd_fn[1];
  assign do_read  = cmd_acc && legal && cmd_fn[2];
  assign do_stop  = cmd_acc && legal && cmd_fn[3];

  // Unpack per-channel inputs into fixed-size, zero-padded arrays
  always_comb begin
    full_arr  = '0;
    empty_arr = '0;
    for (int k = 0; k < 16; k++) begin
      data_arr[k] = '0;
      cnt_arr[k]  = '0;
    end
    for (int k = 0; k < CH_NUM; k++) begin
      data_arr[k]  = bus.DATA_in[32*k +: 32];
      cnt_arr[k]   = 16'(bus.DATAcnt_in[CNT_W*k +: CNT_W]);
      full_arr[k]  = bus.full_in[k];
      empty_arr[k] = bus.empty_in[k];
    end
  end

  // Edge detector history for SELECT_in
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      sel_prev_q <= 16'd0;
      arm_q      <= 1'b0;
    end else begin
      sel_prev_q <= bus.SELECT_in[15:0];
      if (!cmd_nz) arm_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) state_q <= SLEEP;
    else            state_q <= state_d;
  end

  // FSM next state plus next values of the one-cycle pulses
  always_comb begin
    state_d   = state_q;
    rst_out_d = 1'b1;
    rd_d      = '0;
    case (state_q)
      SLEEP:   if (do_start) state_d = RUN;
      RUN:     if (do_stop)  state_d = SLEEP;
      default: state_d = SLEEP;
    endcase
    if (do_start) rst_out_d = 1'b0;
    for (int k = 0; k < CH_NUM; k++)
      rd_d[k] = do_read && !empty_arr[cmd_idx] && (cmd_idx == 4'(k));
  end

`ifdef GPIOCTRL_ERRFLAG_EN
  logic uflow_q, illegal_q;

  // Sticky error flags, cleared by an accepted start
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      uflow_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (do_start) begin
      uflow_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (do_read && empty_arr[cmd_idx]) uflow_q   <= 1'b1;
      if (cmd_acc && !legal)             illegal_q <= 1'b1;
    end
  end

  assign uflow_w   = uflow_q;
  assign illegal_w = illegal_q;
`else
  assign uflow_w   = 1'b0;
  assign illegal_w = 1'b0;
`endif

  // Readback selection: an accepted inquiry/read takes effect on this edge
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    if (do_inq) begin
      mode_d = 1'b0;
      idx_d  = cmd_idx;
    end else if (do_read) begin
      mode_d = 1'b1;
      idx_d  = cmd_idx;
    end
    if (mode_d)
      gpio_d = data_arr[idx_d];
    else
      gpio_d = {state_q, uflow_w, illegal_w, 11'd0, full_arr[idx_d], cnt_arr[idx_d]};
  end

  // Readback and pulse registers
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      mode_q    <= 1'b0;
      idx_q     <= 4'd0;
      gpio_q    <= 32'd0;
      rst_out_q <= 1'b1;
      rd_q      <= '0;
    end else begin
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      gpio_q    <= gpio_d;
      rst_out_q <= rst_out_d;
      rd_q      <= rd_d;
    end
  end

  // Trigger-level write strobes; pair idx+1 beyond TRG_NUM simply matches nothing
  always_comb begin
    wr_h = '0;
    wr_l = '0;
    for (int j = 0; j < TRG_NUM; j++) begin
      wr_h[j] = cmd_acc && legal &&
                ((cmd_fn[4] && ({1'b0, cmd_idx} == 5'(j))) ||
                 (cmd_fn[6] && (({1'b0, cmd_idx} + 5'd1) == 5'(j))));
      wr_l[j] = cmd_acc && legal &&
                ((cmd_fn[5] && ({1'b0, cmd_idx} == 5'(j))) ||
                 (cmd_fn[7] && (({1'b0, cmd_idx} + 5'd1) == 5'(j))));
    end
  end

  // Trigger-level registers: H resets to all ones, L to zero
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      for (int j = 0; j < TRG_NUM; j++) begin
        h_q[j] <= '1;
        l_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < TRG_NUM; j++) begin
        if (wr_h[j]) h_q[j] <= cmd_pay[LVL_W-1:0];
        if (wr_l[j]) l_q[j] <= cmd_pay[LVL_W-1:0];
      end
    end
  end

  // Pack trigger pairs as {H_j, L_j}
  always_comb begin
    bus.TRGLEVEL_out = '0;
    for (int j = 0; j < TRG_NUM; j++)
      bus.TRGLEVEL_out[2*LVL_W*j +: 2*LVL_W] = {h_q[j], l_q[j]};
  end

  assign bus.GPIO_out     = gpio_q;
  assign bus._RESET_out   = rst_out_q;
  assign bus.DATAread_out = rd_q;
  assign bus.SLEAP_out    = (state_q == RUN);
  assign bus.STATE_out    = state_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl_v4.sv
// Directed self-checking bench for gpio_cmd_ctrl_v4 (default parameters).
module tb_gpio_cmd_ctrl_v4;

  localparam int CH_NUM  = 2;
  localparam int CNT_W   = 16;
  localparam int LVL_W   = 14;
  localparam int TRG_NUM = 2;

`ifdef GPIOCTRL_ERRFLAG_EN
  localparam logic [31:0] UF_BIT = 32'h2000_0000;
  localparam logic [31:0] IL_BIT = 32'h1000_0000;
`else
  localparam logic [31:0] UF_BIT = 32'h0;
  localparam logic [31:0] IL_BIT = 32'h0;
`endif

  // Clock / reset
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  gpio_cmd_ctrl_v4_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .LVL_W(LVL_W), .TRG_NUM(TRG_NUM)) bus ();

  gpio_cmd_ctrl_v4 #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .LVL_W(LVL_W), .TRG_NUM(TRG_NUM)) dut (
    .sys_clk   (sys_clk),
    ._RESET_in (rst_n),
    .bus       (bus)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  int pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_sel(input logic [31:0] w);
    bus.SELECT_in = w;
  endtask

  function automatic logic [31:0] lvl(input int j, input bit hi);
    logic [TRG_NUM*2*LVL_W-1:0] t;
    t = bus.TRGLEVEL_out;
    return 32'(t[2*LVL_W*j + (hi ? LVL_W : 0) +: LVL_W]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SELECT_in  = 32'h0;
    bus.DATA_in    = {32'hB0B0_0001, 32'hA0A0_0000};
    bus.DATAcnt_in = {16'h0123, 16'h0007};
    bus.full_in    = 2'b10;
    bus.empty_in   = 2'b01;
    tick(); tick();

    // Reset state
    check("rst_gpio",   bus.GPIO_out, 32'h0);
    check("rst_state",  32'(bus.STATE_out), 32'h0);
    check("rst_sleap",  32'(bus.SLEAP_out), 32'h0);
    check("rst_rstout", 32'(bus._RESET_out), 32'h1);
    check("rst_rd",     32'(bus.DATAread_out), 32'h0);
    check("rst_h0", lvl(0, 1), 32'h3FFF);
    check("rst_l0", lvl(0, 0), 32'h0);
    check("rst_h1", lvl(1, 1), 32'h3FFF);

    rst_n = 1'b1;
    tick();
    check("idle_inq_ch0", bus.GPIO_out, 32'h0000_0007);

    // Start
    drive_sel(32'h0000_0001); tick();
    check("start_pulse", 32'(bus._RESET_out), 32'h0);
    check("start_state", 32'(bus.STATE_out), 32'h1);
    check("start_sleap", 32'(bus.SLEAP_out), 32'h1);
    drive_sel(32'h0); tick();
    check("start_pulse_end", 32'(bus._RESET_out), 32'h1);
    check("start_hold_run",  32'(bus.STATE_out), 32'h1);

    // Inquiry ch1, then refresh with a new count
    drive_sel(32'h0000_0102); tick();
    check("inq_ch1", bus.GPIO_out, 32'h4001_0123);
    drive_sel(32'h0); bus.DATAcnt_in = {16'h0456, 16'h0007}; tick();
    check("inq_refresh", bus.GPIO_out, 32'h4001_0456);

    // Read ch0 while empty: no pulse, underflow
    drive_sel(32'h0000_0004); tick();
    check("rd_empty_nopulse", 32'(bus.DATAread_out), 32'h0);
    drive_sel(32'h0); tick();
    check("rd_empty_nopulse2", 32'(bus.DATAread_out), 32'h0);
    drive_sel(32'h0000_0002); tick();
    check("inq_uflow", bus.GPIO_out, 32'h4000_0007 | UF_BIT);
    drive_sel(32'h0); tick();

    // Read ch0 with data, FWFT data follows
    bus.empty_in = 2'b00;
    exp_q.push_back(32'hA0A0_0000);
    exp_q.push_back(32'hA0A0_0001);
    drive_sel(32'h0000_0004); tick();
    check("rd_pulse", 32'(bus.DATAread_out), 32'h1);
    exp_w = exp_q.pop_front();
    check("rd_data0", bus.GPIO_out, exp_w);
    drive_sel(32'h0); bus.DATA_in = {32'hB0B0_0001, 32'hA0A0_0001}; tick();
    check("rd_pulse_end", 32'(bus.DATAread_out), 32'h0);
    exp_w = exp_q.pop_front();
    check("rd_data1", bus.GPIO_out, exp_w);

    // Trigger levels
    drive_sel(32'h1ABC_0020); tick();
    check("trg_l0", lvl(0, 0), 32'h1ABC);
    drive_sel(32'h0); tick();
    drive_sel(32'h0055_0040); tick();
    check("trg_h1", lvl(1, 1), 32'h0055);
    check("trg_h0", lvl(0, 1), 32'h3FFF);
    check("trg_l1", lvl(1, 0), 32'h0);
    check("trg_l0_hold", lvl(0, 0), 32'h1ABC);
    drive_sel(32'h0); tick();
    drive_sel(32'h0777_0180); tick();
    check("trg_b7_ignored_l1", lvl(1, 0), 32'h0);
    check("trg_b7_ignored_l0", lvl(0, 0), 32'h1ABC);
    drive_sel(32'h0); tick();
    drive_sel(32'h0123_0110); tick();
    check("trg_h1_b4", lvl(1, 1), 32'h0123);
    drive_sel(32'h0); tick();

    // Illegal commands
    drive_sel(32'h0000_0003); tick();
    check("ill2_state", 32'(bus.STATE_out), 32'h1);
    check("ill2_rstout", 32'(bus._RESET_out), 32'h1);
    check("ill2_gpio", bus.GPIO_out, 32'hA0A0_0001);
    drive_sel(32'h0); tick();
    drive_sel(32'h0000_0F04); tick();
    check("illidx_rd", 32'(bus.DATAread_out), 32'h0);
    check("illidx_gpio", bus.GPIO_out, 32'hA0A0_0001);
    drive_sel(32'h0); tick();
    drive_sel(32'h0000_0102); tick();
    check("inq_flags", bus.GPIO_out, 32'h4001_0456 | UF_BIT | IL_BIT);
    drive_sel(32'h0); tick();

    // Held start: exactly one pulse, flags cleared
    pulses = 0;
    drive_sel(32'h0000_0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus._RESET_out === 1'b0) pulses++;
    end
    check("held_start_pulses", 32'(pulses), 32'd1);
    check("start_clears_flags", bus.GPIO_out, 32'h4001_0456);
    drive_sel(32'h0); tick();

    // Stop, and stop again in SLEEP
    drive_sel(32'h0000_0008); tick();
    check("stop_state", 32'(bus.STATE_out), 32'h0);
    check("stop_sleap", 32'(bus.SLEAP_out), 32'h0);
    drive_sel(32'h0); tick();
    check("sleep_inq", bus.GPIO_out, 32'h0001_0456);
    drive_sel(32'h0000_0008); tick();
    check("stop_in_sleep", 32'(bus.STATE_out), 32'h0);
    drive_sel(32'h0); tick();

    // Reset mid-pulse, held command not re-accepted
    drive_sel(32'h0000_0001); tick();
    check("pulse_before_rst", 32'(bus._RESET_out), 32'h0);
    rst_n = 1'b0; #1;
    check("rst_truncates", 32'(bus._RESET_out), 32'h1);
    check("rst_async_gpio", bus.GPIO_out, 32'h0);
    check("rst_async_h1", lvl(1, 1), 32'h3FFF);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus._RESET_out === 1'b0) pulses++;
    end
    check("held_after_rst_pulses", 32'(pulses), 32'd0);
    check("held_after_rst_state", 32'(bus.STATE_out), 32'h0);
    drive_sel(32'h0); tick();
    drive_sel(32'h0000_0001); tick();
    check("rearm_pulse", 32'(bus._RESET_out), 32'h0);
    check("rearm_state", 32'(bus.STATE_out), 32'h1);
    drive_sel(32'h0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
